// File: rtl/bcd_adder_pkg.sv
// Shared types and constants for the two-digit BCD adder.
// Used by bcd_digit_add and bcd_adder.
package bcd_adder_pkg;

    // One BCD digit. Values 10..15 are not valid BCD.
    typedef logic [3:0] digit_t;

    // Sequencer states, one state per clock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TENS = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest valid BCD digit.
    localparam digit_t BCD_MAX   = 4'd9;
    // Correction added to a binary digit sum that went past 9.
    localparam digit_t BCD_ADJ   = 4'd6;
    // Display blank/dash code, driven on every result digit after an input error.
    localparam digit_t DIGIT_ERR = 4'd15;

    // True when d is a legal BCD digit.
    function automatic logic is_bcd(input digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: two digits plus carry-in give one
// digit plus carry-out, using the add-6 correction on a 5-bit binary sum.
module bcd_digit_add
    import bcd_adder_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   cin,
    output digit_t sum,
    output logic   cout
);

    logic [4:0] raw;

    // Binary sum, then add 6 when it exceeds 9 so the low nibble wraps to raw-10.
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = raw > {1'b0, BCD_MAX};
        sum  = cout ? (raw[3:0] + BCD_ADJ) : raw[3:0];
    end

endmodule

// File: rtl/bcd_adder.sv
// Two-digit BCD adder, sequenced IDLE -> ONES -> TENS -> DONE -> IDLE.
// One bcd_digit_add is time-shared: ones digits in ONES, tens digits in TENS.
// Optional feature: define BCD_ADDER_CHECK_EN to enable input digit validation
// (invalid digit -> ONES jumps straight to DONE with err=1 and all digits 15).
module bcd_adder
    import bcd_adder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A2,
    input  logic [3:0] A1,
    input  logic [3:0] B2,
    input  logic [3:0] B1,
    output logic [3:0] s3,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t state;
    state_t state_next;

    // Operands captured on the accepting start edge.
    digit_t a2_q;
    digit_t a1_q;
    digit_t b2_q;
    digit_t b1_q;

    // Carry from the ones digit into the tens digit.
    logic carry;

    // Shared digit adder connections.
    digit_t add_a;
    digit_t add_b;
    logic   add_cin;
    digit_t add_sum;
    logic   add_cout;

    logic accept;
    logic digit_bad;

    assign accept = (state == IDLE) && start;

`ifdef BCD_ADDER_CHECK_EN
    assign digit_bad = !is_bcd(a2_q) || !is_bcd(a1_q) ||
                       !is_bcd(b2_q) || !is_bcd(b1_q);
`else
    assign digit_bad = 1'b0;
`endif

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE; no stalls elsewhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ONES;
            ONES:    state_next = digit_bad ? DONE : TENS;
            TENS:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Feed the shared adder: ones digits with no carry-in, otherwise tens digits with the stored carry.
    always_comb begin
        add_a   = a1_q;
        add_b   = b1_q;
        add_cin = 1'b0;
        if (state == TENS) begin
            add_a   = a2_q;
            add_b   = b2_q;
            add_cin = carry;
        end
    end

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand capture, only on an accepted start so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2_q <= '0;
            a1_q <= '0;
            b2_q <= '0;
            b1_q <= '0;
        end else if (accept) begin
            a2_q <= A2;
            a1_q <= A1;
            b2_q <= B2;
            b1_q <= B1;
        end
    end

    // Result digits and carry; they hold until the next operation overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3    <= '0;
            s2    <= '0;
            s1    <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ONES: begin
                    if (digit_bad) begin
                        s3 <= DIGIT_ERR;
                        s2 <= DIGIT_ERR;
                        s1 <= DIGIT_ERR;
                    end else begin
                        s1    <= add_sum;
                        carry <= add_cout;
                    end
                end
                TENS: begin
                    s2 <= add_sum;
                    s3 <= {3'b000, add_cout};
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_ADDER_CHECK_EN
    logic err_q;

    // Error flag: set when an invalid digit is found, held until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == ONES) && digit_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/bcd_adder.md
BCD_ADDER -- requirements
Module: bcd_adder

Interface
REQ-001 Parameters: none; all widths fixed at 4-bit BCD digits.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to add the operands present this cycle.
REQ-005 A2, A1  in  4 each  operand A tens digit and ones digit (BCD).
REQ-006 B2, B1  in  4 each  operand B tens digit and ones digit (BCD).
REQ-007 s3  out  4  result hundreds digit: 0 or 1, or 15 on error.
REQ-008 s2, s1  out  4 each  result tens digit and ones digit (BCD).
REQ-009 busy  out  1  high while an operation is in progress (states ONES, TENS, DONE).
REQ-010 done  out  1  single-cycle pulse; result on s3/s2/s1 is valid from this cycle on.
REQ-011 err  out  1  invalid-digit flag, qualified by done.

Function
REQ-012 The block SHALL implement the FSM IDLE -> ONES -> TENS -> DONE -> IDLE, one state per clock.
REQ-013 In IDLE, when start=1 at an edge, the block SHALL latch A2/A1/B2/B1 and go to ONES; start=0 keeps it in IDLE.
REQ-014 start SHALL be ignored in ONES, TENS and DONE; the latched operands are not disturbed.
REQ-015 ONES: s1 SHALL be registered as (A1+B1) mod 10, with internal carry = (A1+B1>9).
REQ-016 TENS: t = A2+B2+carry; s2 SHALL be registered as t mod 10 and s3 as 1 if t>9, else 0.
REQ-017 Digit correction SHALL use add-6 adjustment, with a 5-bit intermediate sum; no value exceeds 19.
REQ-018 done SHALL be 1 only in DONE, which is 3 edges after the accepting start edge; no stalls.
REQ-019 s3/s2/s1 SHALL hold their value until the next operation's ONES/TENS updates.
REQ-020 A new start in the cycle after DONE (i.e. in IDLE) SHALL be accepted, giving a back-to-back throughput of one result per 4 cycles.
REQ-021 err SHALL be 0 unless set per REQ-025.

Reset
REQ-022 While rst_n=0 the block SHALL immediately force: state IDLE, busy=0, done=0, err=0, s3=s2=s1=0, carry=0.
REQ-023 If reset is asserted mid-operation, the operation SHALL be abandoned with no done pulse; after release the block SHALL wait in IDLE for a fresh start.

Configuration
REQ-024 Macro BCD_ADDER_CHECK_EN SHALL select input validation.
REQ-025 With BCD_ADDER_CHECK_EN defined: if any latched digit >9, the FSM SHALL go from ONES directly to DONE, with s3=s2=s1=15 and err=1 during DONE. err SHALL then hold until the next accepted start.
REQ-026 Without BCD_ADDER_CHECK_EN: err SHALL be tied to 0, there is no digit check, and invalid digits give unspecified but deterministic results.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, ONES, TENS, DONE), the constants BCD_MAX=9, BCD_ADJ=6 and DIGIT_ERR=15 (the display blank/dash code), and the 4-bit digit typedef.
REQ-028 Sub-module bcd_digit_add SHALL be combinational: two digits plus carry-in to one digit plus carry-out. It is instantiated once and time-shared across ONES and TENS.

Verification
REQ-029 45+38: start pulse -> done 3 cycles later with s3=0, s2=8, s1=3, err=0.
REQ-030 99+99 -> s3=1, s2=9, s1=8; 00+00 -> s3=0, s2=0, s1=0; 05+05 -> s3=0, s2=1, s1=0.
REQ-031 start held high for 6 cycles with operands 12+34 -> exactly one done pulse before IDLE, then a second operation is accepted; first result s2=4, s1=6.
REQ-032 Operands changed on the cycle after start -> the result reflects the latched values only.
REQ-033 rst_n pulsed low during TENS of 77+55 -> outputs go to 0 immediately, no done pulse, and the next 11+22 gives s2=3, s1=3.
REQ-034 With BCD_ADDER_CHECK_EN, A1=12 -> done 2 cycles after start with err=1 and s3=s2=s1=15; without the macro, err stays 0.
